// File: rtl/gen_pipereg_stage.sv
`default_nettype none
// ============================================================================
// gen_pipereg_stage : one valid bit plus enable-gated data register of the pipe
// Rev 1.0
// ============================================================================
module gen_pipereg_stage #(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] RST_VALUE = {DW{1'b0}}
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush_i,
    input  logic          adv_i,
    input  logic          v_i,
    input  logic [DW-1:0] d_i,
    output logic          v_o,
    output logic          v_nxt_o,
    output logic [DW-1:0] d_o
);

    logic          v_q;
    logic          v_d;
    logic [DW-1:0] d_q;
    logic [DW-1:0] d_d;

    // Data loads only when a valid entry moves in; flush drops validity but keeps data.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (adv_i) begin
            v_d = v_i;
            if (v_i) begin
                d_d = d_i;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q <= 1'b0;
            d_q <= RST_VALUE;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o     = v_q;
    assign v_nxt_o = v_d;
    assign d_o     = d_q;

endmodule
`default_nettype wire

// File: rtl/gen_pipereg.sv
`default_nettype none
// ============================================================================
// gen_pipereg : DP-stage valid/ready pipeline register with bubble collapse
// Rev 1.0
// ============================================================================
module gen_pipereg #(
    parameter int            DW       = 32,
    parameter int            DP       = 2,
    parameter logic [DW-1:0] rstValue = {DW{1'b0}}
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [DW-1:0]             enq_data,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [DW-1:0]             deq_data,
    output logic [$clog2(DP+1)-1:0]   count
);

    localparam int CW = $clog2(DP+1);

    generate
        if (DP < 1) begin : g_dp_check
            $error("gen_pipereg: DP must be at least 1");
        end
    endgenerate

    logic [DP-1:0] v_s;
    logic [DP-1:0] v_nxt;
    logic [DP-1:0] v_in;
    logic [DP-1:0] acc;
    logic [DW-1:0] d_s  [DP];
    logic [DW-1:0] d_in [DP];
    logic          acc_run;
    logic          enq_fire;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Ready ripples back from the output: any empty stage lets everything upstream advance.
    always_comb begin
        acc_run    = !v_s[DP-1] || deq_ready;
        acc        = '0;
        acc[DP-1]  = acc_run;
        for (int k = DP - 2; k >= 0; k--) begin
            acc_run = !v_s[k] || acc_run;
            acc[k]  = acc_run;
        end
    end

    assign enq_ready = acc[0] && !flush;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_valid = v_s[DP-1] && !flush;
    assign deq_data  = d_s[DP-1];

    generate
        for (genvar k = 0; k < DP; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign v_in[k] = enq_fire;
                assign d_in[k] = enq_data;
            end else begin : g_body
                assign v_in[k] = v_s[k-1];
                assign d_in[k] = d_s[k-1];
            end

            gen_pipereg_stage #(
                .DW        (DW),
                .RST_VALUE (rstValue)
            ) u_stage (
                .CLK     (CLK),
                .RST     (RST),
                .flush_i (flush),
                .adv_i   (acc[k]),
                .v_i     (v_in[k]),
                .d_i     (d_in[k]),
                .v_o     (v_s[k]),
                .v_nxt_o (v_nxt[k]),
                .d_o     (d_s[k])
            );
        end
    endgenerate

    always_comb begin
        count_d = '0;
        for (int k = 0; k < DP; k++) begin
            count_d = count_d + CW'(v_nxt[k]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_pipereg.sv
`default_nettype none
// ============================================================================
// tb_gen_pipereg : directed and random checks of gen_pipereg (DP=3, 1 and 4)
// Rev 1.0
// ============================================================================
module tb_gen_pipereg;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       enq_valid;
    logic [7:0] enq_data;
    logic       deq_ready;
    logic       enq_ready;
    logic       deq_valid;
    logic [7:0] deq_data;
    logic [1:0] count;

    logic       r1_ev, r1_er, r1_dv, r1_dr;
    logic [7:0] r1_ed, r1_dd;
    logic [0:0] r1_cnt;
    logic       r4_ev, r4_er, r4_dv, r4_dr;
    logic [7:0] r4_ed, r4_dd;
    logic [2:0] r4_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gen_pipereg #(.DW(8), .DP(3), .rstValue(8'h00)) u_dut (
        .CLK(clk), .RST(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .count(count)
    );

    gen_pipereg #(.DW(8), .DP(1), .rstValue(8'h00)) u_dp1 (
        .CLK(clk), .RST(rst), .flush(1'b0),
        .enq_valid(r1_ev), .enq_ready(r1_er), .enq_data(r1_ed),
        .deq_valid(r1_dv), .deq_ready(r1_dr), .deq_data(r1_dd),
        .count(r1_cnt)
    );

    gen_pipereg #(.DW(8), .DP(4), .rstValue(8'h00)) u_dp4 (
        .CLK(clk), .RST(rst), .flush(1'b0),
        .enq_valid(r4_ev), .enq_ready(r4_er), .enq_data(r4_ed),
        .deq_valid(r4_dv), .deq_ready(r4_dr), .deq_data(r4_dd),
        .count(r4_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_data = 8'h00; deq_ready = 1'b0;
        r1_ev = 1'b0; r1_ed = 8'h00; r1_dr = 1'b0;
        r4_ev = 1'b0; r4_ed = 8'h00; r4_dr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (deq_valid !== 1'b0) begin n_bad++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
        n_cmp++; if (deq_data !== 8'h00) begin n_bad++; $display("FAIL reset_deq_data: got %h want 00", deq_data); end
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
    endtask

    task automatic test_streaming();
        logic [7:0] din  [3];
        logic [1:0] ecnt [7];
        logic       exp_v;
        din  = '{8'h11, 8'h22, 8'h33};
        ecnt = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        deq_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            enq_valid = (c < 3);
            enq_data  = 8'h00;
            if (c < 3) enq_data = din[c];
            #1;
            if (c < 3) begin
                n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL stream_enq_ready c%0d: got %b want 1", c, enq_ready); end
            end
            exp_v = (c >= 3) && (c <= 5);
            n_cmp++; if (deq_valid !== exp_v) begin n_bad++; $display("FAIL stream_deq_valid c%0d: got %b want %b", c, deq_valid, exp_v); end
            if (c >= 3 && c <= 5) begin
                n_cmp++; if (deq_data !== din[c-3]) begin n_bad++; $display("FAIL stream_deq_data c%0d: got %h want %h", c, deq_data, din[c-3]); end
            end
            tick();
            n_cmp++; if (count !== ecnt[c]) begin n_bad++; $display("FAIL stream_count c%0d: got %0d want %0d", c, count, ecnt[c]); end
        end
        enq_valid = 1'b0;
    endtask

    task automatic test_stall_fill();
        int   nxt;
        logic exp_r;
        nxt = 0;
        deq_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            enq_valid = 1'b1;
            enq_data  = 8'hA0 + 8'(nxt);
            #1;
            exp_r = (c < 3);
            n_cmp++; if (enq_ready !== exp_r) begin n_bad++; $display("FAIL stall_enq_ready c%0d: got %b want %b", c, enq_ready, exp_r); end
            if (c >= 3) begin
                n_cmp++; if (deq_valid !== 1'b1) begin n_bad++; $display("FAIL stall_deq_valid c%0d: got %b want 1", c, deq_valid); end
                n_cmp++; if (deq_data !== 8'hA0) begin n_bad++; $display("FAIL stall_deq_data c%0d: got %h want a0", c, deq_data); end
            end
            if (c < 3) nxt++;
            tick();
        end
        n_cmp++; if (count !== 2'd3) begin n_bad++; $display("FAIL stall_count: got %0d want 3", count); end
        deq_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            enq_valid = (nxt < 5);
            enq_data  = 8'hA0 + 8'(nxt);
            #1;
            if (nxt < 5) begin
                n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL drain_enq_ready c%0d: got %b want 1", c, enq_ready); end
            end
            n_cmp++; if (deq_valid !== 1'b1) begin n_bad++; $display("FAIL drain_deq_valid c%0d: got %b want 1", c, deq_valid); end
            n_cmp++; if (deq_data !== 8'hA0 + 8'(c)) begin n_bad++; $display("FAIL drain_deq_data c%0d: got %h want %h", c, deq_data, 8'hA0 + 8'(c)); end
            if (nxt < 5) nxt++;
            tick();
        end
        enq_valid = 1'b0;
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_bubble_collapse();
        logic [7:0] exp_d [3];
        exp_d = '{8'h5C, 8'h61, 8'h62};
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        enq_data  = 8'h5C;
        #1;
        n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL bubble_first_ready: got %b want 1", enq_ready); end
        tick();
        enq_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL bubble_idle_ready c%0d: got %b want 1", c, enq_ready); end
            tick();
        end
        n_cmp++; if (deq_valid !== 1'b1) begin n_bad++; $display("FAIL bubble_deq_valid: got %b want 1", deq_valid); end
        n_cmp++; if (deq_data !== 8'h5C) begin n_bad++; $display("FAIL bubble_deq_data: got %h want 5c", deq_data); end
        n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL bubble_count1: got %0d want 1", count); end
        for (int c = 0; c < 3; c++) begin
            enq_valid = 1'b1;
            enq_data  = 8'h61 + 8'(c);
            #1;
            n_cmp++; if (enq_ready !== (c < 2)) begin n_bad++; $display("FAIL bubble_fill_ready c%0d: got %b want %b", c, enq_ready, (c < 2)); end
            if (c < 2) tick();
        end
        n_cmp++; if (count !== 2'd3) begin n_bad++; $display("FAIL bubble_count3: got %0d want 3", count); end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (deq_valid !== 1'b1) begin n_bad++; $display("FAIL bubble_drain_valid c%0d: got %b want 1", c, deq_valid); end
            n_cmp++; if (deq_data !== exp_d[c]) begin n_bad++; $display("FAIL bubble_drain_data c%0d: got %h want %h", c, deq_data, exp_d[c]); end
            tick();
        end
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL bubble_final_count: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        deq_ready = 1'b0;
        enq_valid = 1'b1; enq_data = 8'h31; tick();
        enq_data = 8'h32; tick();
        enq_valid = 1'b0; tick();
        n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 2", count); end
        n_cmp++; if (deq_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid: got %b want 1", deq_valid); end
        flush = 1'b1; enq_valid = 1'b1; enq_data = 8'h99;
        #1;
        n_cmp++; if (enq_ready !== 1'b0) begin n_bad++; $display("FAIL flush_enq_ready: got %b want 0", enq_ready); end
        n_cmp++; if (deq_valid !== 1'b0) begin n_bad++; $display("FAIL flush_deq_valid: got %b want 0", deq_valid); end
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL flush_post_count: got %0d want 0", count); end
        n_cmp++; if (deq_valid !== 1'b0) begin n_bad++; $display("FAIL flush_post_valid: got %b want 0", deq_valid); end
        deq_ready = 1'b1; enq_valid = 1'b1; enq_data = 8'h77;
        #1;
        n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL flush_enq77_ready: got %b want 1", enq_ready); end
        tick();
        enq_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_cmp++; if (deq_valid !== (c == 3)) begin n_bad++; $display("FAIL flush_lat_valid c%0d: got %b want %b", c, deq_valid, (c == 3)); end
            if (c == 3) begin
                n_cmp++; if (deq_data !== 8'h77) begin n_bad++; $display("FAIL flush_lat_data: got %h want 77", deq_data); end
            end
            tick();
        end
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL flush_final_count: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        deq_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            enq_valid = 1'b1;
            enq_data  = 8'hC1 + 8'(c);
            #1;
            n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_enq_ready c%0d: got %b want 1", c, enq_ready); end
            tick();
        end
        n_cmp++; if (count !== 2'd3) begin n_bad++; $display("FAIL rstmid_pre_count: got %0d want 3", count); end
        rst = 1'b1; enq_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
        n_cmp++; if (deq_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", deq_valid); end
        n_cmp++; if (deq_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", deq_data); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_enq_ready: got %b want 1", enq_ready); end
        deq_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (deq_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_leak c%0d: got %b want 0 (data %h)", c, deq_valid, deq_data); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] q1 [$];
        logic [7:0] q4 [$];
        for (int c = 0; c < 10000 + 8; c++) begin
            // Final few cycles drain both pipes so losses show up as leftover entries.
            if (c < 10000) begin
                r1_ev = 1'($urandom_range(0, 1)); r1_ed = 8'($urandom); r1_dr = ($urandom_range(0, 3) != 0);
                r4_ev = 1'($urandom_range(0, 1)); r4_ed = 8'($urandom); r4_dr = ($urandom_range(0, 3) != 0);
            end else begin
                r1_ev = 1'b0; r1_dr = 1'b1;
                r4_ev = 1'b0; r4_dr = 1'b1;
            end
            #1;
            if (r1_dv === 1'b1 && r1_dr) begin
                n_cmp++;
                if (q1.size() == 0) begin n_bad++; $display("FAIL rnd1_extra c%0d: got %h want none", c, r1_dd); end
                else begin
                    if (r1_dd !== q1[0]) begin n_bad++; $display("FAIL rnd1_data c%0d: got %h want %h", c, r1_dd, q1[0]); end
                    void'(q1.pop_front());
                end
            end
            if (r1_ev && r1_er === 1'b1) q1.push_back(r1_ed);
            if (r4_dv === 1'b1 && r4_dr) begin
                n_cmp++;
                if (q4.size() == 0) begin n_bad++; $display("FAIL rnd4_extra c%0d: got %h want none", c, r4_dd); end
                else begin
                    if (r4_dd !== q4[0]) begin n_bad++; $display("FAIL rnd4_data c%0d: got %h want %h", c, r4_dd, q4[0]); end
                    void'(q4.pop_front());
                end
            end
            if (r4_ev && r4_er === 1'b1) q4.push_back(r4_ed);
            tick();
            n_cmp++; if ($isunknown(r1_cnt) || int'(r1_cnt) != q1.size()) begin n_bad++; $display("FAIL rnd1_count c%0d: got %0d want %0d", c, r1_cnt, q1.size()); end
            n_cmp++; if ($isunknown(r4_cnt) || int'(r4_cnt) != q4.size()) begin n_bad++; $display("FAIL rnd4_count c%0d: got %0d want %0d", c, r4_cnt, q4.size()); end
        end
        n_cmp++; if (q1.size() != 0) begin n_bad++; $display("FAIL rnd1_lost: got %0d left want 0", q1.size()); end
        n_cmp++; if (q4.size() != 0) begin n_bad++; $display("FAIL rnd4_lost: got %0d left want 0", q4.size()); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_bubble_collapse();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
